instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 tb/tb_instr_fetch_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Word-addressed instruction fetch: synchronous-read memory, one read register stage, 2-entry output FIFO.
// Optional PC range checking (fetch_err / ERR state) is enabled by defining IFU_RANGE_CHECK_EN.
module instr_fetch_unit #(
  parameter int          DEPTH    = 4096,
  parameter int          AW       = 12,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [31:0]   instr,
  output logic [31:0]   instr_pc,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  output logic          fetch_err
);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] mem [DEPTH];

  logic        pipe_vld;
  logic [31:0] pipe_pc;
  logic [31:0] pipe_dat;

  logic [31:0] fifo_dat [2];
  logic [31:0] fifo_pc  [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;

  logic        pop, push, rd_en, oor;
  logic [2:0]  occ;

  assign instr_valid = (count != 2'd0);
  assign instr       = instr_valid ? fifo_dat[rd_ptr] : 32'd0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]  : 32'd0;

  assign pop  = instr_valid & instr_ready;
  assign push = pipe_vld;

  // Occupancy counts the slot freed by a same-edge pop, which is what allows one read per cycle.
  assign occ   = {1'b0, count} - {2'b00, pop} + {2'b00, pipe_vld};
  assign rd_en = (state == RUN) && !oor && (occ < 3'd2);

`ifdef IFU_RANGE_CHECK_EN
  assign oor       = (pc >= 32'(DEPTH));
  assign fetch_err = (state == ERR);
`else
  assign oor       = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (oor && (count == 2'd0) && !pipe_vld) state_nxt = ERR;
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
    if (redirect_valid) state_nxt = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      pipe_vld <= 1'b0;
      pipe_pc  <= 32'd0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        // The same-edge pop is implied: the whole buffer is emptied anyway.
        pc       <= redirect_pc;
        pipe_vld <= 1'b0;
        count    <= 2'd0;
        rd_ptr   <= 1'b0;
        wr_ptr   <= 1'b0;
      end else begin
        pipe_vld <= rd_en;
        if (rd_en) begin
          pc      <= pc + 32'd1;
          pipe_pc <= pc;
        end
        if (pop)  rd_ptr <= ~rd_ptr;
        if (push) wr_ptr <= ~wr_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dat[wr_ptr] <= pipe_dat;
      fifo_pc[wr_ptr]  <= pipe_pc;
    end
  end

  // Memory is never reset; a read of an address written on the same edge returns the old word.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
    if (rd_en)   pipe_dat <= mem[pc[AW-1:0]];
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (DEPTH=16): vector table plus hand-written memory-write corner case.
module tb_instr_fetch_unit;

`ifdef IFU_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [31:0] prog_data;
  logic        fetch_err;

  instr_fetch_unit #(.DEPTH(16), .AW(4), .RESET_PC(32'd0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .prog_we        (prog_we),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .fetch_err      (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          rdv;
    logic [31:0] rpc;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    bit          eerr;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] memval(input logic [31:0] p);
    logic [31:0] a;
    a = {28'h0, p[3:0]};
    if (a < 32'd4) return 32'h11 * (a + 32'd1);
    return 32'hA000_0000 | a;
  endfunction

  task automatic add(input bit r, input bit rdy, input bit rdv, input logic [31:0] rpc,
                     input bit ev, input logic [31:0] epc, input bit eerr);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rdv = rdv; v.rpc = rpc;
    v.ev = ev; v.epc = ev ? epc : 32'd0; v.einstr = ev ? memval(epc) : 32'd0; v.eerr = eerr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; instr_ready = 1'b0;
    prog_we = 1'b0; prog_addr = 4'd0; prog_data = 32'd0;

    for (int i = 0; i < 16; i++) begin
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = memval(32'(i));
      tick();
    end
    prog_we = 1'b0;

    // reset state
    add(1,0,0,0, 0,0,0);
    add(1,0,0,0, 0,0,0);
    // stream from RESET_PC at full rate
    add(0,1,0,0, 0,0,0);
    add(0,1,0,0, 0,0,0);
    for (int p = 0; p < 4; p++) add(0,1,0,0, 1,32'(p),0);
    // one-cycle reset mid-stream, restart on the third edge
    add(1,1,0,0, 0,0,0);
    add(0,1,0,0, 0,0,0);
    add(0,1,0,0, 0,0,0);
    add(0,1,0,0, 1,0,0);
    // decode stalls for 5 cycles holding pc 0
    for (int k = 0; k < 5; k++) add(0,0,0,0, 1,0,0);
    for (int p = 1; p < 6; p++) add(0,1,0,0, 1,32'(p),0);
    // redirect on the handshake edge of pc 5: pc 6 must never show
    add(0,1,1,32'd8, 0,0,0);
    add(0,1,0,0, 0,0,0);
    add(0,1,0,0, 1,32'd8,0);
    add(0,1,0,0, 1,32'd9,0);
    // two buffered entries dropped by redirect to 0x100
    add(0,0,0,0, 1,32'd9,0);
    add(0,0,1,32'h100, 0,0,0);
    add(0,1,0,0, 0,0,RC);
    add(0,1,0,0, !RC,32'h100,RC);
    add(0,1,0,0, !RC,32'h101,RC);
    // last in-range word, then either wrap or range error
    add(0,1,1,32'd15, 0,0,0);
    add(0,1,0,0, 0,0,0);
    add(0,1,0,0, 1,32'd15,0);
    add(0,1,0,0, !RC,32'd16,0);
    add(0,1,0,0, !RC,32'd17,RC);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; instr_ready = vecs[i].rdy;
      redirect_valid = vecs[i].rdv; redirect_pc = vecs[i].rpc;
      tick();
      chk("instr_valid", i, {31'd0, instr_valid}, {31'd0, vecs[i].ev});
      chk("instr_pc",    i, instr_pc, vecs[i].epc);
      chk("instr",       i, instr, vecs[i].einstr);
      chk("fetch_err",   i, {31'd0, fetch_err}, {31'd0, vecs[i].eerr});
    end

    // Write to the word being read in the same cycle: old data first, new data on refetch.
    rst = 1'b0; instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'd2;
    tick();
    redirect_valid = 1'b0;
    prog_we = 1'b1; prog_addr = 4'd2; prog_data = 32'hDEAD_BEEF;
    chk("wr_bubble", 100, {31'd0, instr_valid}, 32'd0);
    tick();
    prog_we = 1'b0;
    tick();
    chk("wr_old_vld",   101, {31'd0, instr_valid}, 32'd1);
    chk("wr_old_pc",    101, instr_pc, 32'd2);
    chk("wr_old_instr", 101, instr, 32'h33);

    redirect_valid = 1'b1; redirect_pc = 32'd2;
    tick();
    redirect_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      tick();
      seen = instr_valid;
    end
    chk("wr_new_timeout", 102, {31'd0, seen}, 32'd1);
    chk("wr_new_pc",      102, instr_pc, 32'd2);
    chk("wr_new_instr",   102, instr, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
